// File: rtl/wb_scr1_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_scr1_bridge_pkg
// Brief    : Shared types and helpers for the SCR1-to-Wishbone memory bridge.
// Revision : 1.0
// ============================================================================
package wb_scr1_bridge_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } bridge_state_e;

    // Default lane configuration (32-bit bus); wider instances derive their own.
    localparam int SEL_W_DFLT = 4;
    localparam int OFS_W      = $clog2(SEL_W_DFLT);

    function automatic logic [7:0] sel_gen(input type_scr1_mem_width_e width,
                                           input logic [2:0]           offset,
                                           input int                   sel_w);
        logic [7:0] base;
        logic [2:0] ofs;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  base = 8'h01;
            SCR1_MEM_WIDTH_HWORD: base = 8'h03;
            default:              base = 8'h0F;
        endcase
        ofs = offset & 3'(sel_w - 1);
        return base << ofs;
    endfunction

    // Byte/hword copied across the 32-bit lane, lane copied across 64 bits.
    function automatic logic [63:0] wdata_replicate(input type_scr1_mem_width_e width,
                                                    input logic [31:0]          wdata);
        logic [31:0] lane;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  lane = {4{wdata[7:0]}};
            SCR1_MEM_WIDTH_HWORD: lane = {2{wdata[15:0]}};
            default:              lane = wdata;
        endcase
        return {lane, lane};
    endfunction

    function automatic logic misaligned(input type_scr1_mem_width_e width,
                                        input logic [1:0]           ofs);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  return 1'b0;
            SCR1_MEM_WIDTH_HWORD: return ofs[0];
            SCR1_MEM_WIDTH_WORD:  return |ofs;
            default:              return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_scr1_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_scr1_core_if / wb_scr1_wb_if
// Brief    : SCR1 memory-port and Wishbone-master bundles for the bridge.
// Revision : 1.0
// ============================================================================
interface wb_scr1_core_if #(
    parameter int ADDR_W = 32
);
    import wb_scr1_bridge_pkg::*;

    logic                 core_req_i;
    logic                 core_req_ack_o;
    type_scr1_mem_cmd_e   core_cmd_i;
    type_scr1_mem_width_e core_width_i;
    logic [ADDR_W-1:0]    core_addr_i;
    logic [31:0]          core_wdata_i;
    logic [31:0]          core_rdata_o;
    type_scr1_mem_resp_e  core_resp_o;

    modport master (
        output core_req_i, core_cmd_i, core_width_i, core_addr_i, core_wdata_i,
        input  core_req_ack_o, core_rdata_o, core_resp_o
    );

    modport slave (
        input  core_req_i, core_cmd_i, core_width_i, core_addr_i, core_wdata_i,
        output core_req_ack_o, core_rdata_o, core_resp_o
    );
endinterface

interface wb_scr1_wb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   wbm_adr_o;
    logic [DATA_W-1:0]   wbm_dat_o;
    logic [DATA_W-1:0]   wbm_dat_i;
    logic                wbm_we_o;
    logic [DATA_W/8-1:0] wbm_sel_o;
    logic                wbm_stb_o;
    logic                wbm_cyc_o;
    logic                wbm_ack_i;
    logic                wbm_err_i;
    logic                wbm_stall_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_stall_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_stall_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_scr1_mem_bridge_timeout.sv
`default_nettype none
// ============================================================================
// Module   : wb_scr1_bridge_timeout
// Brief    : Bus-cycle watchdog; used only when WB_SCR1_BRIDGE_TIMEOUT_EN is set.
// Revision : 1.0
// ============================================================================
module wb_scr1_bridge_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic busy_i,
    output logic      expired_o
);
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count is zero on the first BUS cycle, so the last allowed cycle sees TIMEOUT_CYC-1.
    always_comb begin
        cnt_d     = busy_i ? cnt_q + 1'b1 : '0;
        expired_o = busy_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/wb_scr1_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wb_scr1_mem_bridge
// Brief    : SCR1 IMEM/DMEM port to Wishbone master (classic or B4 pipelined).
//            Optional bus timeout: define WB_SCR1_BRIDGE_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module wb_scr1_mem_bridge
    import wb_scr1_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int PIPELINED   = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic       wb_clk_i,
    input  wire logic       wb_rst_n_i,
    wb_scr1_core_if.slave   core,
    wb_scr1_wb_if.master    wbm
);
    localparam int                SEL_W    = DATA_W / 8;
    localparam int                OFS_BITS = $clog2(SEL_W);
    localparam logic [ADDR_W-1:0] ADR_MASK = ~(ADDR_W'(SEL_W - 1));

    bridge_state_e     state_q, state_d;
    logic [ADDR_W-1:0] adr_q,   adr_d;
    logic [DATA_W-1:0] dat_q,   dat_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic              we_q,    we_d;
    logic              cyc_q,   cyc_d;
    logic              stb_q,   stb_d;
    logic              err_q,   err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              accept;
    logic              tmo_expired;
    logic [31:0]       rd_lane;

    assign accept = (state_q == ST_IDLE) && core.core_req_i;

    // The 64-bit bus needs to remember which 32-bit lane the core asked for.
    if (DATA_W == 64) begin : g_rd64
        logic lane_q;
        logic lane_d;

        always_comb begin
            lane_d = accept ? core.core_addr_i[2] : lane_q;
        end

        always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
            if (!wb_rst_n_i) begin
                lane_q <= 1'b0;
            end else begin
                lane_q <= lane_d;
            end
        end

        assign rd_lane = lane_q ? wbm.wbm_dat_i[63:32] : wbm.wbm_dat_i[31:0];
    end else begin : g_rd32
        assign rd_lane = wbm.wbm_dat_i[31:0];
    end

`ifdef WB_SCR1_BRIDGE_TIMEOUT_EN
    wb_scr1_bridge_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .busy_i    (state_q == ST_BUS),
        .expired_o (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (core.core_req_i) begin
                    adr_d = core.core_addr_i & ADR_MASK;
                    sel_d = SEL_W'(sel_gen(core.core_width_i,
                                           3'(core.core_addr_i[OFS_BITS-1:0]), SEL_W));
                    we_d  = (core.core_cmd_i == SCR1_MEM_CMD_WR);
                    dat_d = (core.core_cmd_i == SCR1_MEM_CMD_WR)
                          ? DATA_W'(wdata_replicate(core.core_width_i, core.core_wdata_i))
                          : '0;
                    if (misaligned(core.core_width_i, core.core_addr_i[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        state_d = ST_BUS;
                    end
                end
            end

            ST_BUS: begin
                // In B4 mode the strobe is one transfer request, withdrawn once taken.
                if ((PIPELINED != 0) && stb_q && !wbm.wbm_stall_i) begin
                    stb_d = 1'b0;
                end
                if (wbm.wbm_err_i) begin
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wbm.wbm_ack_i) begin
                    err_d   = 1'b0;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = rd_lane;
                    end
                    state_d = ST_RESP;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign core.core_req_ack_o = (state_q == ST_IDLE);
    assign core.core_rdata_o   = rdata_q;
    assign core.core_resp_o    = (state_q != ST_RESP) ? SCR1_MEM_RESP_NOTRDY
                               : (err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK);

    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = stb_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_scr1_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_scr1_mem_bridge
// Brief    : Directed bench: 32-bit classic and 64-bit pipelined bridge instances.
// Revision : 1.0
// ============================================================================
module tb_wb_scr1_mem_bridge;
    import wb_scr1_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    wb_scr1_core_if #(.ADDR_W(32))              c32 ();
    wb_scr1_wb_if   #(.ADDR_W(32), .DATA_W(32)) w32 ();
    wb_scr1_core_if #(.ADDR_W(32))              c64 ();
    wb_scr1_wb_if   #(.ADDR_W(32), .DATA_W(64)) w64 ();

    wb_scr1_mem_bridge #(.ADDR_W(32), .DATA_W(32), .PIPELINED(0), .TIMEOUT_CYC(8)) dut32 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .core(c32), .wbm(w32));
    wb_scr1_mem_bridge #(.ADDR_W(32), .DATA_W(64), .PIPELINED(1), .TIMEOUT_CYC(8)) dut64 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .core(c64), .wbm(w64));

    // Drives a request at a negedge; returns at the negedge of the first BUS cycle.
    task automatic start32(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                           input logic [31:0] addr, input logic [31:0] wdata);
        c32.core_req_i = 1'b1; c32.core_cmd_i = cmd; c32.core_width_i = w;
        c32.core_addr_i = addr; c32.core_wdata_i = wdata;
        @(posedge clk); @(negedge clk);
        c32.core_req_i = 1'b0;
    endtask

    task automatic start64(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                           input logic [31:0] addr, input logic [31:0] wdata);
        c64.core_req_i = 1'b1; c64.core_cmd_i = cmd; c64.core_width_i = w;
        c64.core_addr_i = addr; c64.core_wdata_i = wdata;
        @(posedge clk); @(negedge clk);
        c64.core_req_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        total++; if (c32.core_req_ack_o !== 1'b1) begin bad++; $display("FAIL rst_req_ack got=%b exp=1", c32.core_req_ack_o); end
        total++; if ({w32.wbm_cyc_o, w32.wbm_stb_o, w32.wbm_we_o} !== 3'b000) begin bad++; $display("FAIL rst_cyc_stb_we got=%b exp=000", {w32.wbm_cyc_o, w32.wbm_stb_o, w32.wbm_we_o}); end
        total++; if ({w32.wbm_adr_o, w32.wbm_dat_o, w32.wbm_sel_o} !== 68'h0) begin bad++; $display("FAIL rst_adr_dat_sel got=%h exp=0", {w32.wbm_adr_o, w32.wbm_dat_o, w32.wbm_sel_o}); end
        total++; if (c32.core_resp_o !== SCR1_MEM_RESP_NOTRDY) begin bad++; $display("FAIL rst_resp got=%0d exp=0", c32.core_resp_o); end
        total++; if (c32.core_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", c32.core_rdata_o); end
        total++; if ({w64.wbm_cyc_o, w64.wbm_stb_o, w64.wbm_sel_o} !== 10'h0) begin bad++; $display("FAIL rst64_cyc_stb_sel got=%h exp=0", {w64.wbm_cyc_o, w64.wbm_stb_o, w64.wbm_sel_o}); end
    endtask

    task automatic test_word_read();
        c32.core_req_i = 1'b1; c32.core_cmd_i = SCR1_MEM_CMD_RD; c32.core_width_i = SCR1_MEM_WIDTH_WORD;
        c32.core_addr_i = 32'h100; c32.core_wdata_i = 32'h0;
        total++; if (c32.core_req_ack_o !== 1'b1) begin bad++; $display("FAIL rd_req_ack_idle got=%b exp=1", c32.core_req_ack_o); end
        @(posedge clk); @(negedge clk);
        c32.core_req_i = 1'b0;
        total++; if ({w32.wbm_cyc_o, w32.wbm_stb_o, w32.wbm_we_o} !== 3'b110) begin bad++; $display("FAIL rd_bus1_cyc_stb_we got=%b exp=110", {w32.wbm_cyc_o, w32.wbm_stb_o, w32.wbm_we_o}); end
        total++; if (w32.wbm_sel_o !== 4'hF) begin bad++; $display("FAIL rd_sel got=%h exp=f", w32.wbm_sel_o); end
        total++; if (w32.wbm_adr_o !== 32'h100) begin bad++; $display("FAIL rd_adr got=%h exp=100", w32.wbm_adr_o); end
        total++; if (c32.core_req_ack_o !== 1'b0) begin bad++; $display("FAIL rd_req_ack_bus got=%b exp=0", c32.core_req_ack_o); end
        total++; if (c32.core_resp_o !== SCR1_MEM_RESP_NOTRDY) begin bad++; $display("FAIL rd_resp_bus got=%0d exp=0", c32.core_resp_o); end
        step();
        total++; if ({w32.wbm_cyc_o, w32.wbm_stb_o} !== 2'b11) begin bad++; $display("FAIL rd_bus2_cyc_stb got=%b exp=11", {w32.wbm_cyc_o, w32.wbm_stb_o}); end
        w32.wbm_ack_i = 1'b1; w32.wbm_dat_i = 32'hDEADBEEF;
        step();
        w32.wbm_ack_i = 1'b0; w32.wbm_dat_i = 32'h0;
        total++; if (c32.core_resp_o !== SCR1_MEM_RESP_RDY_OK) begin bad++; $display("FAIL rd_resp got=%0d exp=1", c32.core_resp_o); end
        total++; if (c32.core_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", c32.core_rdata_o); end
        total++; if ({w32.wbm_cyc_o, w32.wbm_stb_o, c32.core_req_ack_o} !== 3'b000) begin bad++; $display("FAIL rd_resp_cyc_stb_ack got=%b exp=000", {w32.wbm_cyc_o, w32.wbm_stb_o, c32.core_req_ack_o}); end
        step();
        total++; if (c32.core_resp_o !== SCR1_MEM_RESP_NOTRDY) begin bad++; $display("FAIL rd_resp_after got=%0d exp=0", c32.core_resp_o); end
        total++; if (c32.core_req_ack_o !== 1'b1) begin bad++; $display("FAIL rd_req_ack_after got=%b exp=1", c32.core_req_ack_o); end
    endtask

    task automatic test_writes();
        start32(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h203, 32'h123456A5);
        total++; if (w32.wbm_sel_o !== 4'b1000) begin bad++; $display("FAIL wb_sel got=%b exp=1000", w32.wbm_sel_o); end
        total++; if (w32.wbm_dat_o !== 32'hA5A5A5A5) begin bad++; $display("FAIL wb_dat got=%h exp=a5a5a5a5", w32.wbm_dat_o); end
        total++; if ({w32.wbm_we_o, w32.wbm_adr_o} !== {1'b1, 32'h200}) begin bad++; $display("FAIL wb_we_adr got=%b/%h exp=1/200", w32.wbm_we_o, w32.wbm_adr_o); end
        w32.wbm_ack_i = 1'b1;
        step();
        w32.wbm_ack_i = 1'b0;
        total++; if (c32.core_resp_o !== SCR1_MEM_RESP_RDY_OK) begin bad++; $display("FAIL wb_resp got=%0d exp=1", c32.core_resp_o); end
        total++; if (c32.core_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL wb_rdata_kept got=%h exp=deadbeef", c32.core_rdata_o); end
        step();
        start32(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h202, 32'hABCD1234);
        total++; if (w32.wbm_sel_o !== 4'b1100) begin bad++; $display("FAIL wh_sel got=%b exp=1100", w32.wbm_sel_o); end
        total++; if (w32.wbm_dat_o !== 32'h12341234) begin bad++; $display("FAIL wh_dat got=%h exp=12341234", w32.wbm_dat_o); end
        w32.wbm_ack_i = 1'b1;
        step();
        w32.wbm_ack_i = 1'b0;
        total++; if (c32.core_resp_o !== SCR1_MEM_RESP_RDY_OK) begin bad++; $display("FAIL wh_resp got=%0d exp=1", c32.core_resp_o); end
        step();
        start32(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h101, 32'h0);
        total++; if ({w32.wbm_sel_o, w32.wbm_we_o} !== 5'b00100) begin bad++; $display("FAIL rb_sel_we got=%b exp=00100", {w32.wbm_sel_o, w32.wbm_we_o}); end
        w32.wbm_ack_i = 1'b1; w32.wbm_dat_i = 32'h11223344;
        step();
        w32.wbm_ack_i = 1'b0; w32.wbm_dat_i = 32'h0;
        total++; if (c32.core_rdata_o !== 32'h11223344) begin bad++; $display("FAIL rb_rdata got=%h exp=11223344", c32.core_rdata_o); end
        step();
    endtask

    task automatic test_misaligned();
        start32(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h101, 32'h0);
        total++; if (w32.wbm_cyc_o !== 1'b0) begin bad++; $display("FAIL mh_cyc got=%b exp=0", w32.wbm_cyc_o); end
        total++; if (c32.core_resp_o !== SCR1_MEM_RESP_RDY_ER) begin bad++; $display("FAIL mh_resp got=%0d exp=2", c32.core_resp_o); end
        total++; if (c32.core_req_ack_o !== 1'b0) begin bad++; $display("FAIL mh_req_ack got=%b exp=0", c32.core_req_ack_o); end
        step();
        total++; if ({c32.core_resp_o, c32.core_req_ack_o} !== {SCR1_MEM_RESP_NOTRDY, 1'b1}) begin bad++; $display("FAIL mh_after got=%b exp=001", {c32.core_resp_o, c32.core_req_ack_o}); end
        start32(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h102, 32'h55);
        total++; if ({w32.wbm_cyc_o, c32.core_resp_o} !== {1'b0, SCR1_MEM_RESP_RDY_ER}) begin bad++; $display("FAIL mw_cyc_resp got=%b exp=010", {w32.wbm_cyc_o, c32.core_resp_o}); end
        step();
    endtask

    task automatic test_ack_err();
        start32(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h300, 32'h0);
        w32.wbm_ack_i = 1'b1; w32.wbm_err_i = 1'b1; w32.wbm_dat_i = 32'hCAFEF00D;
        step();
        w32.wbm_ack_i = 1'b0; w32.wbm_err_i = 1'b0; w32.wbm_dat_i = 32'h0;
        total++; if (c32.core_resp_o !== SCR1_MEM_RESP_RDY_ER) begin bad++; $display("FAIL ae_resp got=%0d exp=2", c32.core_resp_o); end
        total++; if (c32.core_rdata_o !== 32'h11223344) begin bad++; $display("FAIL ae_rdata got=%h exp=11223344", c32.core_rdata_o); end
        total++; if (w32.wbm_cyc_o !== 1'b0) begin bad++; $display("FAIL ae_cyc got=%b exp=0", w32.wbm_cyc_o); end
        step();
    endtask

    task automatic test_pipelined();
        w64.wbm_stall_i = 1'b1;
        start64(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h104, 32'h0);
        total++; if ({w64.wbm_sel_o, w64.wbm_adr_o} !== {8'hF0, 32'h100}) begin bad++; $display("FAIL p_sel_adr got=%h/%h exp=f0/100", w64.wbm_sel_o, w64.wbm_adr_o); end
        for (int i = 0; i < 4; i++) begin
            total++; if ({w64.wbm_cyc_o, w64.wbm_stb_o} !== 2'b11) begin bad++; $display("FAIL p_stb_held cycle=%0d got=%b exp=11", i, {w64.wbm_cyc_o, w64.wbm_stb_o}); end
            if (i == 3) w64.wbm_stall_i = 1'b0;
            step();
        end
        total++; if ({w64.wbm_cyc_o, w64.wbm_stb_o} !== 2'b10) begin bad++; $display("FAIL p_stb_drop got=%b exp=10", {w64.wbm_cyc_o, w64.wbm_stb_o}); end
        w64.wbm_ack_i = 1'b1; w64.wbm_dat_i = 64'h89ABCDEF_01234567;
        step();
        w64.wbm_ack_i = 1'b0; w64.wbm_dat_i = 64'h0;
        total++; if (c64.core_resp_o !== SCR1_MEM_RESP_RDY_OK) begin bad++; $display("FAIL p_resp got=%0d exp=1", c64.core_resp_o); end
        total++; if (c64.core_rdata_o !== 32'h89ABCDEF) begin bad++; $display("FAIL p_rdata_hi got=%h exp=89abcdef", c64.core_rdata_o); end
        step();
        start64(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
        total++; if ({w64.wbm_stb_o, w64.wbm_sel_o} !== {1'b1, 8'h0F}) begin bad++; $display("FAIL p0_stb_sel got=%b/%h exp=1/0f", w64.wbm_stb_o, w64.wbm_sel_o); end
        w64.wbm_ack_i = 1'b1; w64.wbm_dat_i = 64'hAAAA5555_5A5A0F0F;
        step();
        w64.wbm_ack_i = 1'b0; w64.wbm_dat_i = 64'h0;
        total++; if (c64.core_rdata_o !== 32'h5A5A0F0F) begin bad++; $display("FAIL p0_rdata_lo got=%h exp=5a5a0f0f", c64.core_rdata_o); end
        total++; if ({w64.wbm_cyc_o, w64.wbm_stb_o} !== 2'b00) begin bad++; $display("FAIL p0_cyc_stb got=%b exp=00", {w64.wbm_cyc_o, w64.wbm_stb_o}); end
        step();
        start64(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h105, 32'h00000077);
        total++; if (w64.wbm_sel_o !== 8'h20) begin bad++; $display("FAIL pw_sel got=%h exp=20", w64.wbm_sel_o); end
        total++; if (w64.wbm_dat_o !== 64'h77777777_77777777) begin bad++; $display("FAIL pw_dat got=%h exp=7777777777777777", w64.wbm_dat_o); end
        w64.wbm_ack_i = 1'b1;
        step();
        w64.wbm_ack_i = 1'b0;
        total++; if (c64.core_resp_o !== SCR1_MEM_RESP_RDY_OK) begin bad++; $display("FAIL pw_resp got=%0d exp=1", c64.core_resp_o); end
        step();
    endtask

    task automatic test_no_response();
        start32(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h400, 32'h0);
`ifdef WB_SCR1_BRIDGE_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            total++; if (w32.wbm_cyc_o !== 1'b1) begin bad++; $display("FAIL to_cyc_held cycle=%0d got=%b exp=1", i, w32.wbm_cyc_o); end
            step();
        end
        total++; if ({w32.wbm_cyc_o, w32.wbm_stb_o} !== 2'b00) begin bad++; $display("FAIL to_cyc_drop got=%b exp=00", {w32.wbm_cyc_o, w32.wbm_stb_o}); end
        total++; if (c32.core_resp_o !== SCR1_MEM_RESP_RDY_ER) begin bad++; $display("FAIL to_resp got=%0d exp=2", c32.core_resp_o); end
        w32.wbm_ack_i = 1'b1;
        step();
        w32.wbm_ack_i = 1'b0;
        total++; if ({c32.core_resp_o, c32.core_req_ack_o} !== {SCR1_MEM_RESP_NOTRDY, 1'b1}) begin bad++; $display("FAIL to_late_ack got=%b exp=001", {c32.core_resp_o, c32.core_req_ack_o}); end
`else
        for (int i = 0; i < 20; i++) begin
            total++; if (w32.wbm_cyc_o !== 1'b1) begin bad++; $display("FAIL nt_cyc_held cycle=%0d got=%b exp=1", i, w32.wbm_cyc_o); end
            step();
        end
        w32.wbm_ack_i = 1'b1; w32.wbm_dat_i = 32'h0BADF00D;
        step();
        w32.wbm_ack_i = 1'b0; w32.wbm_dat_i = 32'h0;
        total++; if (c32.core_resp_o !== SCR1_MEM_RESP_RDY_OK) begin bad++; $display("FAIL nt_resp got=%0d exp=1", c32.core_resp_o); end
        total++; if (c32.core_rdata_o !== 32'h0BADF00D) begin bad++; $display("FAIL nt_rdata got=%h exp=0badf00d", c32.core_rdata_o); end
        step();
`endif
    endtask

    task automatic test_reset_mid_bus();
        start32(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h500, 32'h0);
        total++; if (w32.wbm_cyc_o !== 1'b1) begin bad++; $display("FAIL rm_cyc_before got=%b exp=1", w32.wbm_cyc_o); end
        rst_n = 1'b0;
        #1;
        total++; if ({w32.wbm_cyc_o, w32.wbm_stb_o} !== 2'b00) begin bad++; $display("FAIL rm_cyc_stb got=%b exp=00", {w32.wbm_cyc_o, w32.wbm_stb_o}); end
        total++; if (c32.core_resp_o !== SCR1_MEM_RESP_NOTRDY) begin bad++; $display("FAIL rm_resp got=%0d exp=0", c32.core_resp_o); end
        total++; if (c32.core_rdata_o !== 32'h0) begin bad++; $display("FAIL rm_rdata got=%h exp=0", c32.core_rdata_o); end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        step();
        total++; if ({c32.core_req_ack_o, w32.wbm_cyc_o, c32.core_resp_o} !== {1'b1, 1'b0, SCR1_MEM_RESP_NOTRDY}) begin bad++; $display("FAIL rm_after got=%b exp=1000", {c32.core_req_ack_o, w32.wbm_cyc_o, c32.core_resp_o}); end
    endtask

    initial begin
        c32.core_req_i = 1'b0; c32.core_cmd_i = SCR1_MEM_CMD_RD; c32.core_width_i = SCR1_MEM_WIDTH_WORD;
        c32.core_addr_i = 32'h0; c32.core_wdata_i = 32'h0;
        c64.core_req_i = 1'b0; c64.core_cmd_i = SCR1_MEM_CMD_RD; c64.core_width_i = SCR1_MEM_WIDTH_WORD;
        c64.core_addr_i = 32'h0; c64.core_wdata_i = 32'h0;
        w32.wbm_dat_i = 32'h0; w32.wbm_ack_i = 1'b0; w32.wbm_err_i = 1'b0; w32.wbm_stall_i = 1'b0;
        w64.wbm_dat_i = 64'h0; w64.wbm_ack_i = 1'b0; w64.wbm_err_i = 1'b0; w64.wbm_stall_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        step();
        test_word_read();
        test_writes();
        test_misaligned();
        test_ack_err();
        test_pipelined();
        test_no_response();
        test_reset_mid_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/wb_scr1_mem_bridge.md
Name: wb_scr1_mem_bridge

Overview:
- Generalised bridge from one SCR1 memory port (IMEM or DMEM) to a Wishbone master.
- Next generation of the fixed-width instr/data masters. Adds:
  - byte-lane select generated from width and address offset;
  - write-data lane replication;
  - Wishbone error propagation;
  - misalignment detection;
  - selectable classic or B4-pipelined bus mode.
- Instantiated once per SCR1 memory port inside the SoC top.

Parameters:
- ADDR_W, 32, Wishbone/SCR1 address width.
- DATA_W, 32, data width. Legal values 32 or 64. SEL_W = DATA_W/8.
- PIPELINED, 0, 0 = Wishbone classic (stb held until ack/err); 1 = B4 pipelined (stb held only until stall_i low).
- TIMEOUT_CYC, 255, bus-cycle timeout in clocks. Used only with the optional feature.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- core_req_i  in  1  SCR1 request valid.
- core_req_ack_o  out  1  request accepted (high only in IDLE).
- core_cmd_i  in  1  type_scr1_mem_cmd_e: RD/WR.
- core_width_i  in  2  type_scr1_mem_width_e: BYTE/HWORD/WORD.
- core_addr_i  in  ADDR_W  byte address.
- core_wdata_i  in  32  write data, LSB-aligned.
- core_rdata_o  out  32  read data; lane selected by addr[2] when DATA_W=64.
- core_resp_o  out  2  type_scr1_mem_resp_e.
- wbm_adr_o  out  ADDR_W  Wishbone address, low log2(SEL_W) bits zero.
- wbm_dat_o  out  DATA_W  write data.
- wbm_dat_i  in  DATA_W  read data.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  SEL_W  byte select.
- wbm_stb_o  out  1  strobe.
- wbm_cyc_o  out  1  cycle.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  bus error.
- wbm_stall_i  in  1  pipeline stall; ignored when PIPELINED=0.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; wbm_cyc_o/wbm_stb_o/wbm_we_o = 0; wbm_adr_o/wbm_dat_o/wbm_sel_o = 0.
  - core_resp_o = NOTRDY; core_rdata_o = 0.
  - Reset mid-cycle drops cyc/stb at once; no response is issued for the aborted access.
- States: IDLE, BUS, RESP.
- IDLE:
  - core_req_ack_o = 1 (combinational from state only).
  - On core_req_i at a clock edge, capture cmd/width/addr/wdata.
  - Aligned access -> BUS; cyc=stb=1 from the next cycle.
  - Misaligned access (HWORD with addr[0]=1, or WORD with addr[1:0]!=0) -> RESP with RDY_ER; no bus cycle.
- Byte select: base mask BYTE=1, HWORD=3, WORD=F, shifted left by addr[log2(SEL_W)-1:0]. For writes, wbm_dat_o carries wdata replicated to every 32-bit lane with byte/hword replicated inside the lane. Reads use the same sel.
- BUS, classic mode: stb held with cyc until ack_i or err_i.
- BUS, pipelined mode:
  - stb deasserts in the cycle after it is sampled with stall_i=0.
  - cyc is held until ack_i or err_i.
  - ack/err in the same cycle as stb with stall_i=0 is legal.
- Completion: on ack_i (err_i=0), drop cyc/stb, register rdata, go to RESP with RDY_OK.
- Error: err_i has priority over ack_i in the same cycle and gives RDY_ER; rdata is unchanged.
- RESP:
  - core_resp_o = RDY_OK or RDY_ER for exactly one cycle, then IDLE with core_resp_o = NOTRDY.
  - core_req_ack_o = 0 in RESP.
- Read data: registered copy of the 32-bit lane addr[2] (DATA_W=64) or the whole word (DATA_W=32). No further byte shifting; the core LSU aligns.
- Latency: acceptance edge T; cyc/stb high during cycle T+1. Zero-wait ack gives resp valid at T+2. Minimum 3 cycles per access.
- Writes return RDY_OK on ack; core_rdata_o is not updated.

Optional Feature:
- Macro: WB_SCR1_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter, cleared on BUS entry, increments each BUS cycle.
  - On reaching TIMEOUT_CYC with no ack/err, cyc/stb drop and RESP issues RDY_ER.
  - A late ack after the timeout is ignored.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- Package wb_scr1_bridge_pkg contains:
  - the state enum;
  - the function sel_gen(width, offset, SEL_W);
  - the function wdata_replicate();
  - localparam OFS_W = $clog2(SEL_W).
- One sub-module, wb_scr1_bridge_timeout (counter + expiry flag), instantiated only under the macro.

Test Plan:
- DATA_W=32, classic: WORD read at 0x100, slave acks at 2nd BUS cycle returning 0xDEADBEEF -> sel=F, adr=0x100, resp RDY_OK with rdata 0xDEADBEEF exactly 1 cycle, req_ack low through BUS/RESP.
- BYTE write 0xA5 at 0x203 -> sel=1000, dat=0xA5A5A5A5, we=1, RDY_OK; HWORD write 0x1234 at 0x202 -> sel=1100, dat=0x12341234.
- HWORD read at 0x101 -> no cyc asserted, RDY_ER on cycle after acceptance.
- Slave asserts ack and err together -> RDY_ER; rdata keeps previous value.
- DATA_W=64, PIPELINED=1: WORD read at 0x104 with stall_i high 3 cycles -> stb high 4 cycles, sel=F0, rdata = upper lane of dat_i.
- Macro on, TIMEOUT_CYC=8, slave never responds -> cyc drops after 8 BUS cycles, RDY_ER. Separately, assert reset during BUS -> cyc/stb low immediately, resp NOTRDY, req_ack=1 after reset release.
